// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gating controller: gates idle domains, re-enables them on activity, reports ready.
// Optional per-domain gating-event counters are built when CLK_GATE_CTRL_STATS_EN is defined.
module clk_gate_ctrl #(
    parameter int N_DOM    = 4,
    parameter int IDLE_CNT = 8,
    parameter int WAKE_LAT = 2
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 SE,
    input  logic                 force_on,
    input  logic [N_DOM-1:0]     busy,
    input  logic [N_DOM-1:0]     wake_req,
    output logic [N_DOM-1:0]     en,
    output logic [N_DOM-1:0]     rdy,
    output logic [N_DOM-1:0]     gated,
    output logic [8*N_DOM-1:0]   gate_cnt
);

    localparam int IW = $clog2(IDLE_CNT + 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_OFF  = 2'd1,
        ST_WAKE = 2'd2
    } state_t;

    generate
        for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dom
            state_t          state_reg;
            logic [IW-1:0]   idle_reg;
            logic [3:0]      wake_reg;
            logic            en_reg;
            logic            rdy_reg;
            logic            gated_reg;
            logic            trigger;
            logic            go_off;

            assign trigger = busy[gi] | wake_req[gi] | force_on;
            // The idle edge that would bring the count to IDLE_CNT is the gating edge.
            assign go_off  = (state_reg == ST_RUN) && !trigger &&
                             (idle_reg == IW'(IDLE_CNT - 1));

            always_ff @(posedge CK) begin
                if (RST) begin
                    state_reg <= ST_RUN;
                    idle_reg  <= '0;
                    wake_reg  <= '0;
                    en_reg    <= 1'b1;
                    rdy_reg   <= 1'b1;
                    gated_reg <= 1'b0;
                end else if (!SE) begin
                    case (state_reg)
                        ST_RUN: begin
                            if (trigger) begin
                                idle_reg <= '0;
                            end else if (go_off) begin
                                state_reg <= ST_OFF;
                                idle_reg  <= '0;
                                en_reg    <= 1'b0;
                                rdy_reg   <= 1'b0;
                                gated_reg <= 1'b1;
                            end else begin
                                idle_reg <= idle_reg + 1'b1;
                            end
                        end
                        ST_OFF: begin
                            if (trigger) begin
                                state_reg <= ST_WAKE;
                                wake_reg  <= 4'd1;
                                en_reg    <= 1'b1;
                                gated_reg <= 1'b0;
                            end
                        end
                        ST_WAKE: begin
                            // Activity inputs are ignored until the clock has settled.
                            if (wake_reg == 4'(WAKE_LAT)) begin
                                state_reg <= ST_RUN;
                                wake_reg  <= '0;
                                idle_reg  <= '0;
                                rdy_reg   <= 1'b1;
                            end else begin
                                wake_reg <= wake_reg + 4'd1;
                            end
                        end
                        default: begin
                            state_reg <= ST_RUN;
                            idle_reg  <= '0;
                            wake_reg  <= '0;
                            en_reg    <= 1'b1;
                            rdy_reg   <= 1'b1;
                            gated_reg <= 1'b0;
                        end
                    endcase
                end
            end

            assign en[gi]    = en_reg;
            assign rdy[gi]   = rdy_reg;
            assign gated[gi] = gated_reg;

`ifdef CLK_GATE_CTRL_STATS_EN
            logic [7:0] cnt_reg;

            always_ff @(posedge CK) begin
                if (RST) begin
                    cnt_reg <= '0;
                end else if (!SE && go_off && (cnt_reg != 8'hFF)) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end

            assign gate_cnt[8*gi +: 8] = cnt_reg;
`endif
        end
    endgenerate

`ifndef CLK_GATE_CTRL_STATS_EN
    assign gate_cnt = '0;
`endif

endmodule
